// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   col_in     keypad columns, active-low, already synchronised to clk
//   row_out    row drive, active-low, exactly one bit low
//   keypad     accepted key code {row[1:0], col[1:0]}, zero unless key_valid
//   key_valid  one-cycle strobe per accepted press
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] keypad,
    output logic       key_valid
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED
    } state_t;

    state_t          state;
    logic [1:0]      row_idx;
    logic [DW-1:0]   div_cnt;
    logic [CW-1:0]   match_cnt;
    logic [CW-1:0]   rel_cnt;
    logic [3:0]      lat_pattern;
    logic [1:0]      lat_col;

    logic            sample;
    logic            single_low;
    logic [1:0]      col_idx;

    assign sample  = (div_cnt == DIV_LAST);
    assign row_out = ~(4'b0001 << row_idx);

    // Only a single low column is a key; several low columns are treated as
    // no key so that ghosting and rollover never produce a code.
    always_comb begin
        single_low = 1'b0;
        col_idx    = 2'd0;
        case (col_in)
            4'b1110: begin single_low = 1'b1; col_idx = 2'd0; end
            4'b1101: begin single_low = 1'b1; col_idx = 2'd1; end
            4'b1011: begin single_low = 1'b1; col_idx = 2'd2; end
            4'b0111: begin single_low = 1'b1; col_idx = 2'd3; end
            default: begin single_low = 1'b0; col_idx = 2'd0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_SCAN;
            row_idx     <= 2'd0;
            div_cnt     <= '0;
            match_cnt   <= '0;
            rel_cnt     <= '0;
            lat_pattern <= 4'hF;
            lat_col     <= 2'd0;
            keypad      <= 4'd0;
            key_valid   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            keypad    <= 4'd0;
            div_cnt   <= sample ? '0 : div_cnt + 1'b1;

            if (sample) begin
                case (state)
                    ST_SCAN: begin
                        if (single_low) begin
                            // row_idx stays put from here on, so it serves as the latched row
                            lat_pattern <= col_in;
                            lat_col     <= col_idx;
                            match_cnt   <= CW'(1);
                            if (DEBOUNCE == 1) begin
                                key_valid <= 1'b1;
                                keypad    <= {row_idx, col_idx};
                                rel_cnt   <= '0;
                                state     <= ST_PRESSED;
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end else begin
                            row_idx <= row_idx + 2'd1;
                        end
                    end

                    ST_DEBOUNCE: begin
                        if (col_in == lat_pattern) begin
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt == DB_LAST) begin
                                key_valid <= 1'b1;
                                keypad    <= {row_idx, lat_col};
                                rel_cnt   <= '0;
                                state     <= ST_PRESSED;
                            end
                        end else begin
                            // bounce: resume scanning after the row that glitched
                            row_idx <= row_idx + 2'd1;
                            state   <= ST_SCAN;
                        end
                    end

                    ST_PRESSED: begin
                        if (col_in == 4'hF) begin
                            if (rel_cnt == DB_LAST) begin
                                row_idx <= 2'd0;
                                div_cnt <= '0;
                                rel_cnt <= '0;
                                state   <= ST_SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + 1'b1;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end

                    default: state <= ST_SCAN;
                endcase
            end
        end
    end

endmodule
